// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the combination-lock sequencer: default parameter
// values, the controller state encoding and the counter width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package lock_pkg;

  localparam int DEF_CODE_LEN       = 5;
  localparam int DEF_MAX_FAIL       = 3;
  localparam int DEF_LOCKOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CHECK   = 3'd3,
    ST_RESULT  = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/lock_controller_if.sv
// -----------------------------------------------------------------------------
// lock_controller_if
// Groups the host handshake and the detector-facing signals of the lock
// controller.
//   start, code      host -> controller  attempt request and candidate code
//   busy             controller -> host  high outside IDLE
//   granted, denied  controller -> host  one-cycle result pulses
//   locked_out       controller -> host  high during lockout
//   lock_reset, lock_update, lock_key   controller -> detector
//   lock_unlock      detector -> controller
// Modports: master (host/detector side), slave (controller side).
// -----------------------------------------------------------------------------
interface lock_controller_if #(
  parameter int CODE_LEN = lock_pkg::DEF_CODE_LEN
);
  logic                start;
  logic [CODE_LEN-1:0] code;
  logic                busy;
  logic                lock_reset;
  logic                lock_update;
  logic                lock_key;
  logic                lock_unlock;
  logic                granted;
  logic                denied;
  logic                locked_out;

  modport master (
    output start, code, lock_unlock,
    input  busy, lock_reset, lock_update, lock_key, granted, denied, locked_out
  );

  modport slave (
    input  start, code, lock_unlock,
    output busy, lock_reset, lock_update, lock_key, granted, denied, locked_out
  );
endinterface

// File: rtl/lock_lockout_timer.sv
// -----------------------------------------------------------------------------
// lock_lockout_timer
// Loadable down-counter timing the lockout period.
//   clk     in  clock
//   reset   in  asynchronous active-high reset
//   load_i  in  load LOCKOUT_CYCLES-1 (takes priority over counting)
//   en_i    in  count down while nonzero
//   done_o  out counter is zero
// -----------------------------------------------------------------------------
module lock_lockout_timer
  import lock_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CW = cnt_w(LOCKOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(LOCKOUT_CYCLES - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lock_controller.sv
// -----------------------------------------------------------------------------
// lock_controller
// Sequencer and attempt manager for the serial combination-lock detector.
// Latches a code on start, clears the detector, shifts the code MSB first,
// samples the unlock flag and reports granted/denied. MAX_FAIL consecutive
// denials start a LOCKOUT_CYCLES-long lockout.
//   clk    in  clock
//   reset  in  asynchronous active-high reset
//   bus    lock_controller_if.slave (handshake, result and detector signals)
// -----------------------------------------------------------------------------
module lock_controller
  import lock_pkg::*;
#(
  parameter int CODE_LEN       = DEF_CODE_LEN,
  parameter int MAX_FAIL       = DEF_MAX_FAIL,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  lock_controller_if.slave   bus
);

  localparam int IW = cnt_w(CODE_LEN);
  localparam int FW = cnt_w(MAX_FAIL + 1);

  state_e              state_q, state_d;
  logic [CODE_LEN-1:0] shreg_q, shreg_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [FW-1:0]       fail_q, fail_d;
  logic                result_q, result_d;

  logic [FW-1:0]       fail_inc;
  logic                tmr_load;
  logic                tmr_done;

  assign fail_inc = fail_q + FW'(1);

  lock_lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (tmr_load),
    .en_i   (state_q == ST_LOCKOUT),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    result_d = result_q;
    tmr_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shreg_d = bus.code;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        idx_d   = IW'(CODE_LEN - 1);
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (idx_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      ST_CHECK: begin
        result_d = bus.lock_unlock;
        state_d  = ST_RESULT;
      end
      ST_RESULT: begin
        if (result_q) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end else begin
          fail_d = fail_inc;
          if (fail_inc == FW'(MAX_FAIL)) begin
            // Load on the transition so the first LOCKOUT cycle already
            // holds LOCKOUT_CYCLES-1 and the lockout lasts exactly
            // LOCKOUT_CYCLES cycles.
            tmr_load = 1'b1;
            state_d  = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
      fail_q   <= '0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      fail_q   <= fail_d;
      result_q <= result_d;
    end
  end

  // Outputs decode registered state; lock_reset also follows the reset input
  // so the detector is held cleared for the whole reset.
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.lock_reset  = reset | (state_q == ST_CLEAR);
  assign bus.lock_update = (state_q == ST_SHIFT);
  assign bus.lock_key    = (state_q == ST_SHIFT) ? shreg_q[idx_q] : 1'b0;
  assign bus.granted     = (state_q == ST_RESULT) &  result_q;
  assign bus.denied      = (state_q == ST_RESULT) & ~result_q;
  assign bus.locked_out  = (state_q == ST_LOCKOUT);

endmodule

// File: tb/tb_lock_controller.sv
module tb_lock_controller;
  import lock_pkg::*;

  localparam int CL = DEF_CODE_LEN;
  localparam int MF = DEF_MAX_FAIL;
  localparam int LC = DEF_LOCKOUT_CYCLES;
  localparam logic [CL-1:0] SECRET = 5'b01011;

  typedef struct packed {
    logic busy;
    logic lrst;
    logic upd;
    logic key;
    logic gr;
    logic dn;
    logic lo;
  } ov_t;

  localparam ov_t IDLE_V = 7'b0000000;
  localparam ov_t RST_V  = 7'b0100000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lock_controller_if #(.CODE_LEN(CL)) bus();

  lock_controller #(
    .CODE_LEN(CL), .MAX_FAIL(MF), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Detector stand-in: shifts key bits on update, unlocks once the last
  // CL bits since its reset equal SECRET.
  logic [CL-1:0] det_hist;
  int            det_cnt;
  always @(posedge clk) begin
    if (bus.lock_reset) begin
      det_hist <= '0;
      det_cnt  <= 0;
    end else if (bus.lock_update) begin
      det_hist <= {det_hist[CL-2:0], bus.lock_key};
      if (det_cnt < CL) det_cnt <= det_cnt + 1;
    end
  end
  assign bus.lock_unlock = (det_cnt == CL) && (det_hist == SECRET);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ov_t mk(input logic b, input logic r, input logic u, input logic k,
                             input logic g, input logic d, input logic l);
    ov_t v;
    v.busy = b; v.lrst = r; v.upd = u; v.key = k; v.gr = g; v.dn = d; v.lo = l;
    return v;
  endfunction

  // Reference model: an accepted attempt expands into a queue of expected
  // per-cycle outputs; an empty queue means the block is idle.
  ov_t sched[$];
  ov_t cur = IDLE_V;
  int  fails = 0;

  always @(posedge clk) begin
    if (reset) begin
      sched.delete();
      fails = 0;
      cur = IDLE_V;
    end else begin
      if (!cur.busy && bus.start) begin
        logic [CL-1:0] c;
        logic ok;
        c  = bus.code;
        ok = (c == SECRET);
        sched.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < CL; i++) sched.push_back(mk(1, 0, 1, c[CL-1-i], 0, 0, 0));
        sched.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        sched.push_back(mk(1, 0, 0, 0, ok, !ok, 0));
        if (ok) begin
          fails = 0;
        end else begin
          fails++;
          if (fails == MF) begin
            fails = 0;
            for (int i = 0; i < LC; i++) sched.push_back(mk(1, 0, 0, 0, 0, 0, 1));
          end
        end
      end
      if (sched.size() > 0) cur = sched.pop_front();
      else cur = IDLE_V;
    end
  end

  ov_t act_v, exp_v;
  always @(negedge clk) begin
    if (mon_en) begin
      act_v = {bus.busy, bus.lock_reset, bus.lock_update, bus.lock_key,
               bus.granted, bus.denied, bus.locked_out};
      exp_v = reset ? RST_V : cur;
      chk("cycle_outputs", 32'(act_v), 32'(exp_v));
    end
  end

  // One attempt observed for 30 cycles after acceptance (k=1 is CLEAR).
  task automatic run(input logic [CL-1:0] c, input bit hold, input bit poke,
                     input logic [CL-1:0] c2, output logic [CL-1:0] keys,
                     output int gr_at, output int dn_at, output int bfall,
                     output int lo_cnt, output int upd_cnt);
    keys = '0; gr_at = -1; dn_at = -1; bfall = -1; lo_cnt = 0; upd_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.code  = c;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.lock_update) begin
        if (upd_cnt < CL) keys = {keys[CL-2:0], bus.lock_key};
        upd_cnt++;
      end
      if (bus.granted && gr_at < 0) gr_at = k;
      if (bus.denied && dn_at < 0) dn_at = k;
      if (!bus.busy && bfall < 0) bfall = k;
      if (bus.locked_out) lo_cnt++;
      #2;
      if (hold && k == 3) bus.code = c2;
      if (hold && k == 10) bus.start = 1'b0;
      if (poke) bus.start = bus.locked_out;
    end
  endtask

  logic [CL-1:0] keys;
  int gr_at, dn_at, bfall, lo_cnt, upd_cnt, lo_sum, pulses;

  initial begin
    bus.start = 1'b0;
    bus.code  = '0;
    #0 reset = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_lock_reset", bus.lock_reset, 1);
    chk("reset_update", bus.lock_update, 0);
    @(posedge clk); #1 reset = 1'b0;

    run(SECRET, 0, 0, '0, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt);
    chk("ok_keys", keys, 5'b01011);
    chk("ok_granted_cycle", gr_at, 8);
    chk("ok_no_denied", dn_at, -1);
    chk("ok_busy_fall", bfall, 9);

    run(5'b00000, 0, 0, '0, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt);
    chk("bad_denied_cycle", dn_at, 8);
    chk("bad_no_granted", gr_at, -1);
    chk("bad_no_lockout", lo_cnt, 0);
    run(5'b10101, 0, 0, '0, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt);
    chk("bad2_no_lockout", lo_cnt, 0);
    run(5'b11111, 0, 1, '0, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt);
    chk("bad3_denied_cycle", dn_at, 8);
    chk("lockout_len", lo_cnt, 16);
    chk("lockout_no_update", upd_cnt, 5);
    chk("lockout_busy_fall", bfall, 25);
    run(SECRET, 0, 0, '0, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt);
    chk("after_lockout_granted", gr_at, 8);

    // Fail count clears on grant: W W C W W never locks out.
    lo_sum = 0;
    run(5'b00001, 0, 0, '0, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt); lo_sum += lo_cnt;
    run(5'b00010, 0, 0, '0, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt); lo_sum += lo_cnt;
    run(SECRET,   0, 0, '0, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt); lo_sum += lo_cnt;
    chk("clear_mid_granted", gr_at, 8);
    run(5'b00011, 0, 0, '0, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt); lo_sum += lo_cnt;
    run(5'b00100, 0, 0, '0, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt); lo_sum += lo_cnt;
    chk("clear_last_denied", dn_at, 8);
    chk("clear_no_lockout", lo_sum, 0);

    // Reset during the third update cycle (fail count is 2 here).
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.code  = SECRET;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_was_updating", bus.lock_update, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_update", bus.lock_update, 0);
    chk("rst_mid_key", bus.lock_key, 0);
    chk("rst_mid_lock_reset", bus.lock_reset, 1);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_lock_reset", bus.lock_reset, 1);
    end
    @(posedge clk); #1 reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.granted || bus.denied) pulses++;
    end
    chk("rst_no_pulse", pulses, 0);
    lo_sum = 0;
    run(5'b00000, 0, 0, '0, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt); lo_sum += lo_cnt;
    run(5'b00000, 0, 0, '0, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt); lo_sum += lo_cnt;
    chk("rst_fail_count_lost", lo_sum, 0);
    run(SECRET, 0, 0, '0, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt);
    chk("rst_then_granted", gr_at, 8);

    // start held through the attempt with code changed while busy.
    run(SECRET, 1, 0, 5'b00000, keys, gr_at, dn_at, bfall, lo_cnt, upd_cnt);
    chk("hold_keys", keys, 5'b01011);
    chk("hold_granted", gr_at, 8);
    chk("hold_busy_fall", bfall, 9);
    chk("hold_second_denied", dn_at, 17);
    chk("hold_update_count", upd_cnt, 10);

    // Randomized traffic checked by the per-cycle model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (reset) reset = ($urandom_range(0, 1) == 1);
      else       reset = ($urandom_range(0, 299) == 0);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.code  = ($urandom_range(0, 2) == 0) ? SECRET : CL'($urandom);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("final_idle", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_controller.md
# lock_controller

Sequencer and attempt manager for the serial combination-lock detector. Accepts a parallel code word through a start/busy handshake, clears the detector, then shifts the code into it one bit per cycle. It samples the detector's unlock flag and reports granted or denied. Repeated failures trigger a timed lockout. The block sits between the keypad/host front end and the detector, and is the only driver of the detector's key, update and reset inputs.

## Interface
- CODE_LEN, 5: code word length in bits, ≥1.
- MAX_FAIL, 3: consecutive denials that trigger lockout, ≥1.
- LOCKOUT_CYCLES, 16: lockout duration in clock cycles, ≥1.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request to try code; accepted only in IDLE.
- code  in  CODE_LEN  candidate code; bit CODE_LEN-1 is shifted first.
- busy  out  1  high in every state except IDLE.
- lock_reset  out  1  detector reset; high while reset is asserted and in CLEAR.
- lock_update  out  1  detector update strobe; high only in SHIFT.
- lock_key  out  1  detector key bit; valid when lock_update is high, 0 otherwise.
- lock_unlock  in  1  detector unlock flag, Moore output of the detector.
- granted  out  1  one-cycle pulse: attempt succeeded.
- denied  out  1  one-cycle pulse: attempt failed.
- locked_out  out  1  high throughout LOCKOUT.

## Operation
- **State machine.** States are IDLE, CLEAR, SHIFT, CHECK, RESULT, LOCKOUT. All outputs are decoded from registered state; the only exception is lock_reset, which ORs in the reset input.
- **IDLE.**
  - If start=1: latch code into the shift register and go to CLEAR.
  - Otherwise hold.
- **CLEAR.** One cycle with lock_reset=1. Bit index is set to CODE_LEN-1. Go to SHIFT.
- **SHIFT.** lock_update=1 and lock_key=code[index] for exactly CODE_LEN cycles, MSB first. Index decrements each cycle; go to CHECK after the index-0 cycle.
- **CHECK.** Register lock_unlock into a result flag and go to RESULT.
- **RESULT.**
  - granted=1 if the result flag is set, else denied=1; exactly one of the two is high.
  - On grant: clear the fail counter and go to IDLE.
  - On deny: increment the fail counter. If the new count equals MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.
- **LOCKOUT.**
  - Down-counter is loaded with LOCKOUT_CYCLES-1 on entry. locked_out=1 and start is ignored.
  - When the counter reaches 0: clear the fail counter and go to IDLE.
- **Ignored start.** start is ignored in every state except IDLE; code is not re-latched while busy.
- **Counter widths.**
  - Fail counter: $clog2(MAX_FAIL+1) bits; it never exceeds MAX_FAIL.
  - Lockout counter: $clog2(LOCKOUT_CYCLES) bits, minimum 1.
  - Bit index: $clog2(CODE_LEN) bits, minimum 1.
- **Code changes.** Changes on code after acceptance have no effect on the running attempt.

## Timing
Let start be sampled high in IDLE on the edge ending cycle N.

| Cycle | State | Outputs |
|---|---|---|
| N+1 | CLEAR | lock_reset=1, busy=1 |
| N+2 … N+1+CODE_LEN | SHIFT | one bit per cycle |
| N+2+CODE_LEN | CHECK | lock_unlock sampled |
| N+3+CODE_LEN | RESULT | granted or denied pulse |
| N+4+CODE_LEN | IDLE or LOCKOUT | next start accepted in IDLE |

- With defaults, the result appears at N+8, and busy is high for cycles N+1 through N+8.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles; busy and locked_out fall together.
- **Reset values:** state=IDLE, busy=0, lock_update=0, lock_key=0, granted=0, denied=0, locked_out=0, all counters 0, lock_reset=1 for as long as reset is held.
- **Reset mid-operation** (any state, including LOCKOUT): immediate return to IDLE, fail count lost, no granted/denied pulse emitted.
- **Start on the first IDLE cycle** after RESULT or LOCKOUT is accepted normally (back-to-back attempts).

## Structure
- **Shared package lock_pkg:** state enum/localparams, default CODE_LEN/MAX_FAIL/LOCKOUT_CYCLES values, and the width helper for counters.
- **Sub-module lock_lockout_timer:** loadable down-counter with a done flag, parameterised by LOCKOUT_CYCLES. Everything else stays in lock_controller.

## Test plan
- **Correct code.** Detector programmed for 01011; start with code=5'b01011 at cycle N.
  - Key stream on lock_key during update cycles N+2..N+6: 0,1,0,1,1.
  - granted=1 at N+8 only; busy falls at N+9.
- **Wrong code.** code=5'b00000: denied pulse at N+8, granted never asserts, fail count=1.
- **Lockout and recovery.**
  - Three consecutive wrong attempts: third denied pulse, then locked_out=1 for exactly 16 cycles.
  - start pulses during lockout are ignored: no lock_update activity.
  - A correct code afterwards is granted.
- **Fail count clears on grant.** Two wrong attempts, one correct, then two wrong: no lockout occurs.
- **Reset mid-SHIFT.** Assert reset during the third update cycle.
  - Outputs go to reset values immediately and lock_reset=1 while reset is held.
  - No result pulse; the next correct attempt is granted.
- **Start while busy.** start held high with code changed mid-attempt: the original code is shifted, and a second attempt begins on the first IDLE cycle.
